platform_scroller: RTL
======================

Name: platform_scroller

Overview:
Generates the `plataform_start`/`plataform_end` row band consumed by the VGA timing/colour stage, which paints rows in [start, end) red.
- On a scroll request from game logic, moves the band down by a fixed distance over several frames, wrapping at the bottom of the active area.
- Paces motion on the VGA stage's own `vsync`, so band updates land in vertical blanking.

Parameters:
- V_ACTIVE, 480, visible lines; position wraps modulo this value.
- INIT_POS, 400, band top row after reset; must be < V_ACTIVE.
- THICKNESS, 16, band height in rows; 1 <= THICKNESS < V_ACTIVE.
- STEP_PX, 4, maximum rows moved per frame; >= 1.
- SCROLL_DIST, 64, total rows moved per request; >= 1.

Ports:
- clk  in  1  single clock, VGA pixel clock domain; every register is clocked on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- vsync  in  1  active-low vsync from the VGA stage; treated as asynchronous.
- scroll_req  in  1  one-cycle request pulse from game logic.
- plataform_start  out  10  band top row, inclusive.
- plataform_end  out  10  band bottom row, exclusive.
- busy  out  1  high while a scroll is in progress.
- scroll_done  out  1  one-cycle pulse when a scroll completes.

Behaviour:
- Reset (reset=0, asynchronous): pos=INIT_POS, remaining=0, state=IDLE, sync flops=1, busy=0, scroll_done=0, pending=0.
  - Outputs at reset: plataform_start=400, plataform_end=416.
  - Asserting reset mid-scroll aborts immediately to these values; no scroll_done pulse.
- Frame tick:
  - vsync passes through a 2-flop synchronizer, then a falling-edge detect.
  - tick is a one-cycle pulse, 3 clk after the vsync fall at the input.
- Outputs:
  - plataform_start = pos (registered).
  - plataform_end = min(pos+THICKNESS, V_ACTIVE), registered and updated in the same cycle as pos.
  - The band is clipped at the bottom edge, never wrapped; end >= start at all times.
- FSM, 3 states:
  - IDLE: busy=0. On scroll_req: remaining<=SCROLL_DIST, go to SCROLL. A tick in the same cycle as the accept is ignored; the first step happens on the next tick.
  - SCROLL: busy=1. On tick:
    - step = min(STEP_PX, remaining)
    - npos = pos+step, computed 11 bits wide
    - pos <= (npos >= V_ACTIVE) ? npos-V_ACTIVE : npos
    - remaining <= remaining-step
    - if remaining-step == 0, go to DONE
  - DONE: scroll_done=1 for exactly one cycle, busy=0, go to IDLE. pos holds.
- scroll_req while in SCROLL or DONE: ignored, unless the optional feature is enabled.
- Between ticks pos is stable. At most one step is applied per frame.
- scroll_req and a tick are edge-independent; both may coincide. Outcome is as defined above.

Optional Feature:
- Macro: PLATFORM_REQ_QUEUE_EN.
- Defined: adds a 1-deep pending flag.
  - scroll_req in SCROLL or DONE sets pending (further requests coalesce into it).
  - On leaving DONE with pending=1: go straight to SCROLL with remaining=SCROLL_DIST and clear pending. busy drops for the DONE cycle only.
  - Reset clears pending.
- Undefined: no pending flag; requests while busy are dropped.

Decomposition:
- Shared package/include platform_defs holds:
  - V_ACTIVE (480) and position width (10), shared with the VGA stage;
  - FSM state encodings IDLE=2'd0, SCROLL=2'd1, DONE=2'd2.
- One sub-module: vsync_tick_sync (2-flop synchronizer plus falling-edge detect, async active-low reset). It is reusable by other per-frame blocks.

Test Plan:
- Reset, then 5 frames with no request -> start=400, end=416, busy=0, no scroll_done; async reset asserted mid-cycle takes effect without a clk edge.
- One scroll_req, defaults -> busy=1 next cycle; start steps 404,408,...,464 over 16 ticks; end=480 once start>=464; scroll_done 1-cycle pulse after the 16th tick; busy=0.
- Second scroll_req from pos=464 -> 468,472,476,0,4,...,48 (wrap at 480); end=480 at start=468/472/476, end=16 at start=0, end=64 at start=48.
- Overrides STEP_PX=5, SCROLL_DIST=12 from reset -> 405,410,412 on 3 ticks (short final step); done after tick 3.
- scroll_req pulsed during SCROLL -> without macro: single scroll, final pos 464. With PLATFORM_REQ_QUEUE_EN: busy low one cycle, second scroll runs, final pos 48.
- Assert reset at the 8th tick of a scroll (pos=432) -> start=400, end=416, busy=0, no scroll_done; a new request after release scrolls normally from 400.

Source files
------------

// File: rtl/platform_scroller_pkg.sv
// Shared definitions for the platform scroller and the VGA stage that consumes
// its band: active-area height, row-position width, FSM state encodings and
// a helper that computes the clipped band end row.
package platform_defs;
    localparam int V_ACTIVE_LINES = 480;
    localparam int POS_W          = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCROLL = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Exclusive bottom row of the band. The band is clipped at the bottom of
    // the active area and never wraps, so end >= start always holds.
    function automatic logic [POS_W-1:0] band_end(input logic [POS_W-1:0] p,
                                                  input logic [POS_W:0]   thick,
                                                  input logic [POS_W:0]   vact);
        logic [POS_W:0] s;
        s = {1'b0, p} + thick;
        return (s > vact) ? vact[POS_W-1:0] : s[POS_W-1:0];
    endfunction
endpackage

// File: rtl/platform_scroller_vsync_tick_sync.sv
// vsync_tick_sync: brings an asynchronous active-low vsync into the clk domain
// through a 2-flop synchronizer and emits a registered one-cycle tick on its
// falling edge. The tick rises 3 clk edges after vsync falls at the input.
// Ports: clk, reset (async active-low), vsync (async, active-low), tick.
module vsync_tick_sync (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    output logic tick
);
    logic s1, s2, s3;

    // Sync flops reset high (vsync idle level) so reset release alone does
    // not look like a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s3   <= 1'b1;
            tick <= 1'b0;
        end else begin
            s1   <= vsync;
            s2   <= s1;
            s3   <= s2;
            tick <= s3 & ~s2;
        end
    end
endmodule

// File: rtl/platform_scroller.sv
// platform_scroller: produces the [plataform_start, plataform_end) row band
// painted red by the VGA stage. A scroll_req moves the band down SCROLL_DIST
// rows, at most STEP_PX rows per frame, paced by the vsync falling edge so
// updates land in vertical blanking. The top row wraps modulo V_ACTIVE; the
// bottom row is clipped to V_ACTIVE.
// Ports: clk, reset (async active-low), vsync (async, active-low),
//   scroll_req (1-cycle pulse), plataform_start/plataform_end (10 bits),
//   busy (scroll in progress), scroll_done (1-cycle completion pulse).
// Optional: PLATFORM_REQ_QUEUE_EN adds a 1-deep pending request flag so a
//   request arriving while busy starts another scroll right after DONE.
module platform_scroller
    import platform_defs::*;
#(
    parameter int V_ACTIVE    = V_ACTIVE_LINES,
    parameter int INIT_POS    = 400,
    parameter int THICKNESS   = 16,
    parameter int STEP_PX     = 4,
    parameter int SCROLL_DIST = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync,
    input  logic             scroll_req,
    output logic [POS_W-1:0] plataform_start,
    output logic [POS_W-1:0] plataform_end,
    output logic             busy,
    output logic             scroll_done
);
    localparam int RW = 16;

    state_t           state, state_n;
    logic             tick;
    logic [POS_W-1:0] pos, pos_wrap, band_e;
    logic [RW-1:0]    remaining, step, rem_next;
    logic [POS_W:0]   npos;
    logic             load, do_step;

    vsync_tick_sync u_tick (
        .clk   (clk),
        .reset (reset),
        .vsync (vsync),
        .tick  (tick)
    );

    // Step arithmetic; npos is one bit wider so pos+step cannot overflow
    // before the wrap compare.
    always_comb begin
        step     = (remaining > RW'(STEP_PX)) ? RW'(STEP_PX) : remaining;
        rem_next = remaining - step;
        npos     = {1'b0, pos} + (POS_W+1)'(step);
        pos_wrap = (npos >= (POS_W+1)'(V_ACTIVE)) ?
                   POS_W'(npos - (POS_W+1)'(V_ACTIVE)) : POS_W'(npos);
        band_e   = band_end(pos_wrap, (POS_W+1)'(THICKNESS), (POS_W+1)'(V_ACTIVE));
    end

`ifdef PLATFORM_REQ_QUEUE_EN
    logic pending, pend_set, pend_clr;
`endif

    always_comb begin
        state_n     = state;
        busy        = 1'b0;
        scroll_done = 1'b0;
        load        = 1'b0;
        do_step     = 1'b0;
`ifdef PLATFORM_REQ_QUEUE_EN
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // A tick coinciding with the accept is ignored on purpose.
                if (scroll_req) begin
                    load    = 1'b1;
                    state_n = SCROLL;
                end
            end
            SCROLL: begin
                busy = 1'b1;
`ifdef PLATFORM_REQ_QUEUE_EN
                pend_set = scroll_req;
`endif
                if (tick) begin
                    do_step = 1'b1;
                    if (rem_next == '0)
                        state_n = DONE;
                end
            end
            DONE: begin
                scroll_done = 1'b1;
                state_n     = IDLE;
`ifdef PLATFORM_REQ_QUEUE_EN
                // A request landing in DONE coalesces with the pending one.
                if (pending || scroll_req) begin
                    load     = 1'b1;
                    pend_clr = 1'b1;
                    state_n  = SCROLL;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            remaining       <= '0;
            pos             <= POS_W'(INIT_POS);
            plataform_start <= POS_W'(INIT_POS);
            plataform_end   <= band_end(POS_W'(INIT_POS), (POS_W+1)'(THICKNESS),
                                        (POS_W+1)'(V_ACTIVE));
        end else begin
            state <= state_n;
            if (load)
                remaining <= RW'(SCROLL_DIST);
            else if (do_step)
                remaining <= rem_next;
            if (do_step) begin
                pos             <= pos_wrap;
                plataform_start <= pos_wrap;
                plataform_end   <= band_e;
            end
        end
    end

`ifdef PLATFORM_REQ_QUEUE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= 1'b0;
        else if (pend_clr)
            pending <= 1'b0;
        else if (pend_set)
            pending <= 1'b1;
    end
`endif
endmodule
